// File: rtl/mpadd_pkg.sv
// Shared types and sizing helpers for the limb-serial add/subtract unit.
package mpadd_pkg;

  // Control FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of LIMB-bit slices needed to cover WIDTH bits
  function automatic int unsigned nlimb(input int unsigned width, input int unsigned limb);
    return (width + limb - 1) / limb;
  endfunction

  // Width of a counter that can hold 0..n
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/limb_addsub.sv
// Combinational LIMB-bit adder/subtractor with carry chaining.
// Subtract is a + ~b + cin; the caller seeds cin=1 on the lowest slice.
module limb_addsub #(
  parameter int unsigned LIMB = 64
) (
  input  logic [LIMB-1:0] a_i,
  input  logic [LIMB-1:0] b_i,
  input  logic            sub_i,
  input  logic            cin_i,
  output logic [LIMB-1:0] sum_o,
  output logic            cout_o
);

  localparam int unsigned LW = LIMB + 1;

  logic [LIMB-1:0] b_eff;

  assign b_eff = sub_i ? ~b_i : b_i;

  // One slice of the ripple, carry-out in the extra top bit
  assign {cout_o, sum_o} = LW'(a_i) + LW'(b_eff) + LW'(cin_i);

endmodule

// File: rtl/mpaddsub_serial.sv
// Multi-precision add/subtract processed one LIMB-bit slice per cycle,
// least significant slice first, using a single shared limb adder.
module mpaddsub_serial
  import mpadd_pkg::*;
#(
  parameter int unsigned WIDTH = 1027,
  parameter int unsigned LIMB  = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH:0]   result,
  output logic             done,
  output logic             busy
);

  localparam int unsigned NLIMB = nlimb(WIDTH, LIMB);
  localparam int unsigned PADW  = NLIMB * LIMB;
  localparam int unsigned CW    = cnt_width(NLIMB);
  localparam int unsigned RW    = WIDTH + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NLIMB - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PADW-1:0] a_q, a_d;
  logic [PADW-1:0] b_q, b_d;
  logic [PADW-1:0] sum_q, sum_d;
  logic            cy_q, cy_d;
  logic            sub_q, sub_d;
  logic [WIDTH:0]  result_q, result_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  logic [LIMB-1:0] limb_sum;
  logic            limb_cout;
  logic [PADW-1:0] sum_shift;

  // Shared slice adder always works on the bottom limb of the shifting operands
  limb_addsub #(
    .LIMB(LIMB)
  ) u_limb (
    .a_i   (a_q[LIMB-1:0]),
    .b_i   (b_q[LIMB-1:0]),
    .sub_i (sub_q),
    .cin_i (cy_q),
    .sum_o (limb_sum),
    .cout_o(limb_cout)
  );

  // New slice enters at the top of the working register; after NLIMB shifts
  // slice 0 has reached the bottom
  assign sum_shift = (sum_q >> LIMB) | (PADW'(limb_sum) << (PADW - LIMB));

  // Next-state, datapath and output decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    cy_d     = cy_q;
    sub_d    = sub_q;
    result_d = result_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          a_d     = PADW'(in_a);
          b_d     = PADW'(in_b);
          sum_d   = '0;
          cy_d    = subtract;
          sub_d   = subtract;
        end
      end
      ST_RUN: begin
        a_d   = a_q >> LIMB;
        b_d   = b_q >> LIMB;
        sum_d = sum_shift;
        cy_d  = limb_cout;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d  = ST_DONE;
          // Top bit is carry-out for add, borrow (inverted carry) for subtract;
          // when padding exists the same bit already sits in sum_shift[WIDTH]
          result_d = RW'({limb_cout ^ sub_q, sum_shift});
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      cy_q     <= 1'b0;
      sub_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      cy_q     <= cy_d;
      sub_q    <= sub_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_mpaddsub_serial.sv
// Directed bench: default-size and small (WIDTH=8, LIMB=3) instances.
module tb_mpaddsub_serial;

  localparam int W   = 1027;
  localparam int NL  = 17;
  localparam int WS  = 8;
  localparam int NLS = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  logic          start_b = 1'b0, sub_b = 1'b0;
  logic [W-1:0]  a_b = '0, b_b = '0;
  logic [W:0]    result_b;
  logic          done_b, busy_b;

  logic          start_s = 1'b0, sub_s = 1'b0;
  logic [WS-1:0] a_s = '0, b_s = '0;
  logic [WS:0]   result_s;
  logic          done_s, busy_s;

  int checks = 0;
  int errors = 0;

  logic [W:0]  prev_big = '0;
  logic [WS:0] prev_small = '0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W:0]   exp;
  } vec_big_t;

  typedef struct {
    logic [WS-1:0] a;
    logic [WS-1:0] b;
    logic          sub;
    logic [WS:0]   exp;
  } vec_small_t;

  localparam int NVB = 9;
  localparam int NVS = 7;
  vec_big_t   vb[NVB];
  vec_small_t vs[NVS];

  mpaddsub_serial u_big (
    .clk(clk), .resetn(resetn), .start(start_b), .subtract(sub_b),
    .in_a(a_b), .in_b(b_b), .result(result_b), .done(done_b), .busy(busy_b)
  );

  mpaddsub_serial #(.WIDTH(WS), .LIMB(3)) u_small (
    .clk(clk), .resetn(resetn), .start(start_s), .subtract(sub_s),
    .in_a(a_s), .in_b(b_s), .result(result_s), .done(done_s), .busy(busy_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got hi=%h lo=%h expected hi=%h lo=%h",
               nm, act[W:W-3], act[127:0], exp[W:W-3], exp[127:0]);
    end
  endtask

  // Called at a negedge. Edge k after acceptance is observed at the negedge before it.
  task automatic op_big(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic [W:0] exp, input string nm);
    int bad = 0;
    logic [W:0] got = '0;
    start_b = 1'b1; a_b = a; b_b = b; sub_b = sub;
    @(posedge clk);
    @(negedge clk);
    start_b = 1'b0; a_b = ~a; b_b = a; sub_b = ~sub;
    for (int k = 1; k <= NL + 1; k++) begin
      if (done_b !== (k == NL + 1)) bad++;
      if (busy_b !== (k <= NL)) bad++;
      if (k <= NL && result_b !== prev_big) bad++;
      if (k == NL + 1) got = result_b;
      @(posedge clk);
      @(negedge clk);
    end
    chk({nm, "_timing"}, (W+1)'(bad), '0);
    chk({nm, "_res"}, got, exp);
    chk({nm, "_pulse"}, (W+1)'({done_b, busy_b}), '0);
    prev_big = exp;
  endtask

  task automatic op_small(input logic [WS-1:0] a, input logic [WS-1:0] b, input logic sub,
                          input logic [WS:0] exp, input string nm);
    int bad = 0;
    logic [WS:0] got = '0;
    start_s = 1'b1; a_s = a; b_s = b; sub_s = sub;
    @(posedge clk);
    @(negedge clk);
    start_s = 1'b0; a_s = ~a; b_s = a; sub_s = ~sub;
    for (int k = 1; k <= NLS + 1; k++) begin
      if (done_s !== (k == NLS + 1)) bad++;
      if (busy_s !== (k <= NLS)) bad++;
      if (k <= NLS && result_s !== prev_small) bad++;
      if (k == NLS + 1) got = result_s;
      @(posedge clk);
      @(negedge clk);
    end
    chk({nm, "_timing"}, (W+1)'(bad), '0);
    chk({nm, "_res"}, (W+1)'(got), (W+1)'(exp));
    chk({nm, "_pulse"}, (W+1)'({done_s, busy_s}), '0);
    prev_small = exp;
  endtask

  initial begin
    logic [W-1:0] all1;
    int bad;
    all1 = '1;

    vb[0] = '{W'(1), W'(1), 1'b0, (W+1)'(2)};
    vb[1] = '{all1, W'(1), 1'b0, {1'b1, {W{1'b0}}}};
    vb[2] = '{W'(0), W'(1), 1'b1, {(W+1){1'b1}}};
    vb[3] = '{W'(5), W'(5), 1'b1, '0};
    vb[4] = '{all1, all1, 1'b0, {{W{1'b1}}, 1'b0}};
    vb[5] = '{W'(64'hFFFF_FFFF_FFFF_FFFF), W'(1), 1'b0, (W+1)'(1) << 64};
    vb[6] = '{W'(1) << 64, W'(1), 1'b1, (W+1)'(64'hFFFF_FFFF_FFFF_FFFF)};
    vb[7] = '{W'(0), all1, 1'b1, {1'b1, {(W-1){1'b0}}, 1'b1}};
    vb[8] = '{all1, W'(0), 1'b1, {1'b0, all1}};

    vs[0] = '{8'hFF, 8'h01, 1'b0, 9'h100};
    vs[1] = '{8'h00, 8'hFF, 1'b1, 9'h101};
    vs[2] = '{8'h7F, 8'h01, 1'b0, 9'h080};
    vs[3] = '{8'h55, 8'hAA, 1'b1, 9'h1AB};
    vs[4] = '{8'h80, 8'h80, 1'b0, 9'h100};
    vs[5] = '{8'hC8, 8'h64, 1'b1, 9'h064};
    vs[6] = '{8'hFF, 8'hFF, 1'b0, 9'h1FE};

    // Reset state
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_big_res", result_b, '0);
    chk("rst_big_flags", (W+1)'({done_b, busy_b}), '0);
    chk("rst_small_res", (W+1)'(result_s), '0);
    chk("rst_small_flags", (W+1)'({done_s, busy_s}), '0);
    resetn = 1'b1;

    for (int i = 0; i < NVS; i++) op_small(vs[i].a, vs[i].b, vs[i].sub, vs[i].exp, $sformatf("small%0d", i));
    for (int i = 0; i < NVB; i++) op_big(vb[i].a, vb[i].b, vb[i].sub, vb[i].exp, $sformatf("big%0d", i));

    // Back-to-back: start held high, operands disturbed mid-run, extra start pulse
    start_b = 1'b1; a_b = W'(3); b_b = W'(4); sub_b = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bad = 0;
    for (int k = 1; k <= 3 * (NL + 1) + 4; k++) begin
      if (done_b !== ((k % (NL + 1) == 0) && (k <= 3 * (NL + 1)))) bad++;
      if (k == 5 || k == NL + 6 || k == 2 * (NL + 1) + 5) begin
        a_b = W'(32'h1234_5678); b_b = W'(99); sub_b = ~sub_b;
      end
      if (k == NL + 1) begin
        chk("b2b_res1", result_b, (W+1)'(7));
        a_b = all1; b_b = W'(2); sub_b = 1'b1;
      end
      if (k == 2 * (NL + 1)) begin
        chk("b2b_res2", result_b, {1'b0, {(W-3){1'b1}}, 3'b101});
        a_b = W'(1) << (W - 1); b_b = W'(1) << (W - 1); sub_b = 1'b0;
      end
      if (k == 2 * (NL + 1) + 4) start_b = 1'b0;
      if (k == 2 * (NL + 1) + 8) start_b = 1'b1;
      if (k == 2 * (NL + 1) + 9) start_b = 1'b0;
      if (k == 3 * (NL + 1)) chk("b2b_res3", result_b, {1'b1, {W{1'b0}}});
      @(posedge clk);
      @(negedge clk);
    end
    chk("b2b_done_pattern", (W+1)'(bad), '0);
    prev_big = {1'b1, {W{1'b0}}};

    // Reset asserted in RUN cycle 10 aborts the operation
    start_b = 1'b1; a_b = W'(7); b_b = W'(3); sub_b = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start_b = 1'b0;
    for (int k = 1; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_res", result_b, '0);
    chk("abort_flags", (W+1)'({done_b, busy_b}), '0);
    prev_big = '0;
    prev_small = '0;
    resetn = 1'b1;
    op_big(W'(100), W'(58), 1'b1, (W+1)'(42), "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mpaddsub_serial.md
MPADDSUB_SERIAL -- requirements
Module: mpaddsub_serial

Interface
REQ-001 Parameter WIDTH, default 1027, operand width in bits; SHALL be at least 2.
REQ-002 Parameter LIMB, default 64, bits processed per cycle; SHALL satisfy 1 <= LIMB <= WIDTH.
REQ-003 Derived constant NLIMB = ceil(WIDTH/LIMB), the number of compute cycles per operation.
REQ-004 clk  in  1  single clock; all logic SHALL be sampled on the rising edge.
REQ-005 resetn  in  1  synchronous, active-low reset.
REQ-006 start  in  1  request; SHALL be accepted only on an edge where busy=0.
REQ-007 subtract  in  1  mode select: 0 = add, 1 = subtract; sampled together with start.
REQ-008 in_a  in  WIDTH  operand A; sampled together with start.
REQ-009 in_b  in  WIDTH  operand B; sampled together with start.
REQ-010 result  out  WIDTH+1  last completed result.
REQ-011 done  out  1  single-cycle pulse; result is valid and updated.
REQ-012 busy  out  1  high while an operation is in progress.

Function
REQ-013 Add mode SHALL produce result = (in_a + in_b) mod 2^(WIDTH+1), so result[WIDTH] is the carry-out.
REQ-014 Subtract mode SHALL produce result = (in_a - in_b) mod 2^(WIDTH+1), so result[WIDTH]=1 iff in_a < in_b.
REQ-015 Operands SHALL be zero-extended to NLIMB*LIMB bits internally; padding SHALL never alter the results of REQ-013 and REQ-014.
REQ-016 FSM states: IDLE, RUN, DONE.
REQ-017 Transition IDLE->RUN on an accepted start.
REQ-018 In RUN, the block SHALL process one LIMB-bit slice per cycle, least significant slice first, with a carry/borrow register chaining the slices.
REQ-019 Transition RUN->DONE after exactly NLIMB RUN cycles.
REQ-020 Transition DONE->IDLE unless start=1, in which case DONE->RUN (back-to-back operation).
REQ-021 done SHALL be high only in DONE; it SHALL rise exactly NLIMB+1 edges after the edge that accepted start.
REQ-022 busy SHALL be high only in RUN.
REQ-023 Operands and mode SHALL be latched at acceptance; input changes after acceptance SHALL have no effect.
REQ-024 start while busy=1 SHALL be ignored; it SHALL NOT be queued.
REQ-025 result SHALL change only on the edge entering DONE, and SHALL be held stable until the next DONE.
REQ-026 Limb-serial partial sums SHALL be held in a working register separate from result.

Reset
REQ-027 With resetn=0 at an edge: state=IDLE, result=0, done=0, busy=0, carry register=0, working and operand registers=0.
REQ-028 Reset during RUN or DONE SHALL abort the operation; no done pulse SHALL follow for the aborted operation.
REQ-029 start sampled on the first edge after resetn returns high SHALL be accepted.

Structure
REQ-030 Package mpadd_pkg SHALL hold the function nlimb(WIDTH, LIMB), the cycle-counter width clog2(NLIMB+1), and the FSM state enumeration.
REQ-031 One sub-module, limb_addsub: combinational LIMB-bit add/subtract with carry-in and carry-out, instantiated once.
REQ-032 The limb counter SHALL be sized from mpadd_pkg; no design-wide combinational adder of WIDTH bits SHALL exist.

Verification
REQ-033 Defaults (NLIMB=17): a=1, b=1, add -> done at edge 18 after start; result=2; busy high for 17 cycles.
REQ-034 Defaults: a=2^1027-1, b=1, add -> result=2^1027 (result[1027]=1, all other bits 0).
REQ-035 Defaults: a=0, b=1, subtract -> result=2^1028-1 (all ones); a=5, b=5, subtract -> result=0.
REQ-036 WIDTH=8, LIMB=3 (NLIMB=3): a=8'hFF, b=8'h01, add -> 9'h100 at edge 4; a=8'h00, b=8'hFF, subtract -> 9'h101.
REQ-037 Defaults: start held high through three operations; in_a changed mid-RUN; extra start pulses during RUN -> exactly three done pulses, each one cycle wide and 18 edges apart, each result computed from its latched operands.
REQ-038 Defaults: resetn=0 asserted in RUN cycle 10 -> all outputs 0 the next cycle; no done; a new start after reset completes correctly.
